fpu_normaliser_seq: RTL and testbench

- Multi-cycle, parametrised post-arithmetic normaliser for the FPU datapath. It sits between the add/mul mantissa stage and the rounding stage.
- Repeatedly left-shifts the working mantissa and decrements the exponent until the hidden bit is set or the exponent reaches its floor.
- Shifts up to STEP bit-positions per clock.
- Valid/ready handshakes on both sides. Reports how many single-bit steps were applied.

---
 rtl/fpu_normaliser_seq.sv | 123 ++++++++++++
 tb/tb_fpu_normaliser_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_normaliser_seq.sv
// Multi-cycle post-arithmetic normaliser: shifts the mantissa left (pulling in guard/round)
// and decrements the exponent until the hidden bit is set or the exponent hits its floor.
module fpu_normaliser_seq #(
  parameter int EXP_W  = 10,
  parameter int MAN_W  = 27,
  parameter int HIDDEN = 23,
  parameter int EMIN   = -126,
  parameter int STEP   = 1,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] z_e_in,
  input  logic [MAN_W-1:0] z_m_in,
  input  logic             guard_in,
  input  logic             round_bit_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] z_e_out,
  output logic [MAN_W-1:0] z_m_out,
  output logic             guard_out,
  output logic             round_bit_out,
  output logic [CNT_W-1:0] steps
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  // The floor is compared one bit wider so a negative EMIN never aliases.
  localparam logic signed [EXP_W:0] EMIN_X = (EXP_W+1)'(EMIN);
  localparam int                    SW     = CNT_W + $clog2(STEP + 1) + 1;
  localparam logic [CNT_W-1:0]      SAT    = '1;

  state_t state, state_next;

  logic [EXP_W-1:0] e_q, e_n;
  logic [MAN_W-1:0] m_q, m_n;
  logic             g_q, g_n;
  logic             r_q, r_n;
  logic [CNT_W-1:0] steps_q, steps_n;
  logic [SW-1:0]    cnt;
  logic [SW-1:0]    sum;

  function automatic logic can_step(input logic [EXP_W-1:0] ev, input logic [MAN_W-1:0] mv);
    return !mv[HIDDEN] && ($signed({ev[EXP_W-1], ev}) > EMIN_X);
  endfunction

  assign in_ready      = (state == IDLE);
  assign out_valid     = (state == DONE);
  assign z_e_out       = e_q;
  assign z_m_out       = m_q;
  assign guard_out     = g_q;
  assign round_bit_out = r_q;
  assign steps         = steps_q;

  // Up to STEP single-bit steps, re-checking the stop condition before each one.
  always_comb begin
    e_n = e_q;
    m_n = m_q;
    g_n = g_q;
    r_n = r_q;
    cnt = '0;
    for (int i = 0; i < STEP; i++) begin
      if (can_step(e_n, m_n)) begin
        e_n = e_n - 1'b1;
        m_n = {m_n[MAN_W-2:0], g_n};
        g_n = r_n;
        r_n = 1'b0;
        cnt = cnt + SW'(1);
      end
    end
    sum     = SW'(steps_q) + cnt;
    steps_n = (sum > SW'(SAT)) ? SAT : sum[CNT_W-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = NORM;
      NORM:    if (!can_step(e_q, m_q)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q     <= '0;
      m_q     <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      steps_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            e_q     <= z_e_in;
            m_q     <= z_m_in;
            g_q     <= guard_in;
            r_q     <= round_bit_in;
            steps_q <= '0;
          end
        end
        NORM: begin
          // When no step is possible these equal the current values, so the registers hold.
          e_q     <= e_n;
          m_q     <= m_n;
          g_q     <= g_n;
          r_q     <= r_n;
          steps_q <= steps_n;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_normaliser_seq.sv
// Self-checking bench: a STEP=1 and a STEP=4 normaliser share inputs and are compared
// against a closed-form model of the normalisation result and latency.
module tb_fpu_normaliser_seq;

  typedef struct packed {
    logic [9:0]  e;
    logic [26:0] m;
    logic        g;
    logic        r;
    logic [5:0]  s;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [9:0]  z_e_in = '0;
  logic [26:0] z_m_in = '0;
  logic        guard_in = 1'b0;
  logic        round_bit_in = 1'b0;

  logic        in_ready, out_valid, guard_out, round_bit_out;
  logic [9:0]  z_e_out;
  logic [26:0] z_m_out;
  logic [5:0]  steps;
  logic        in_ready4, out_valid4, guard_out4, round_bit_out4;
  logic [9:0]  z_e_out4;
  logic [26:0] z_m_out4;
  logic [5:0]  steps4;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  fpu_normaliser_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .z_e_in(z_e_in), .z_m_in(z_m_in), .guard_in(guard_in), .round_bit_in(round_bit_in),
    .out_valid(out_valid), .out_ready(out_ready), .z_e_out(z_e_out), .z_m_out(z_m_out),
    .guard_out(guard_out), .round_bit_out(round_bit_out), .steps(steps)
  );

  fpu_normaliser_seq #(.STEP(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .z_e_in(z_e_in), .z_m_in(z_m_in), .guard_in(guard_in), .round_bit_in(round_bit_in),
    .out_valid(out_valid4), .out_ready(out_ready), .z_e_out(z_e_out4), .z_m_out(z_m_out4),
    .guard_out(guard_out4), .round_bit_out(round_bit_out4), .steps(steps4)
  );

  // Treat {m,g,r} as one register; normalising is a left shift by n, where n is the
  // distance from the leading one to the hidden position, capped by the exponent headroom.
  task automatic model(input logic [9:0] e, input logic [26:0] m, input logic g, input logic r,
                       input int step, output res_t x, output int lat);
    logic [28:0] xv;
    int ei, lead, nn, ne, n;
    xv   = {m, g, r};
    ei   = int'($signed(e));
    lead = -1;
    for (int b = 0; b <= 25; b++) if (xv[b]) lead = b;
    if (m[23])          nn = 0;
    else if (lead < 0)  nn = 1 << 20;
    else                nn = 25 - lead;
    ne  = (ei > -126) ? ei + 126 : 0;
    n   = (nn < ne) ? nn : ne;
    xv  = (n >= 29) ? 29'd0 : (xv << n);
    x.e = 10'(ei - n);
    x.m = xv[28:2];
    x.g = xv[1];
    x.r = xv[0];
    x.s = (n > 63) ? 6'd63 : 6'(n);
    lat = (n + step - 1) / step + 1;
  endtask

  // Present one operand to both instances and capture each result when out_valid rises.
  task automatic do_op(input logic [9:0] e, input logic [26:0] m, input logic g, input logic r,
                       input bit release_out, output res_t d1, output res_t d4,
                       output int lat1, output int lat4);
    bit got1 = 0, got4 = 0;
    int guard = 0;
    lat1 = -1;
    lat4 = -1;
    d1 = '0;
    d4 = '0;
    while (!(in_ready && in_ready4) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    z_e_in = e; z_m_in = m; guard_in = g; round_bit_in = r;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 400 && !(got1 && got4); cyc++) begin
      @(posedge clk); #1;
      if (!got1 && out_valid) begin
        got1 = 1; lat1 = cyc; d1 = {z_e_out, z_m_out, guard_out, round_bit_out, steps};
      end
      if (!got4 && out_valid4) begin
        got4 = 1; lat4 = cyc; d4 = {z_e_out4, z_m_out4, guard_out4, round_bit_out4, steps4};
      end
    end
    if (release_out) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tests_run++;
    if ({in_ready, out_valid, in_ready4, out_valid4} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL reset_handshake got=%b want=1010", {in_ready, out_valid, in_ready4, out_valid4});
    end
    tests_run++;
    if ({z_e_out, z_m_out, guard_out, round_bit_out, steps, z_e_out4, z_m_out4, guard_out4, round_bit_out4, steps4} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data got e=%h m=%h s=%0d e4=%h m4=%h s4=%0d want all zero",
               z_e_out, z_m_out, steps, z_e_out4, z_m_out4, steps4);
    end
  endtask

  // Directed vectors with hand-derived expectations, checked on the matching instance.
  task automatic test_directed;
    res_t d1, d4, want;
    int lat1, lat4, wl;
    logic [9:0]  ve[4] = '{10'd5, 10'd0, 10'h383, 10'd20};
    logic [26:0] vm[4] = '{27'h0800000, 27'h0200000, 27'h0000001, 27'h0004000};
    logic [1:0]  vgr[4] = '{2'b11, 2'b11, 2'b00, 2'b00};
    res_t        vexp[4];
    int          vlat[4] = '{1, 3, 2, 4};
    vexp[0] = '{e:10'd5,   m:27'h0800000, g:1'b1, r:1'b1, s:6'd0};
    vexp[1] = '{e:10'h3FE, m:27'h0800003, g:1'b0, r:1'b0, s:6'd2};
    vexp[2] = '{e:10'h382, m:27'h0000002, g:1'b0, r:1'b0, s:6'd1};
    vexp[3] = '{e:10'd11,  m:27'h0800000, g:1'b0, r:1'b0, s:6'd9};
    for (int i = 0; i < 4; i++) begin
      do_op(ve[i], vm[i], vgr[i][1], vgr[i][0], 1'b1, d1, d4, lat1, lat4);
      want = vexp[i];
      wl   = vlat[i];
      if (i == 3) begin
        d1 = d4;
        lat1 = lat4;
      end
      tests_run++;
      if (d1 !== want) begin
        failures++;
        $display("[TB] FAIL directed%0d_data got e=%h m=%h g=%b r=%b s=%0d want e=%h m=%h g=%b r=%b s=%0d",
                 i, d1.e, d1.m, d1.g, d1.r, d1.s, want.e, want.m, want.g, want.r, want.s);
      end
      tests_run++;
      if (lat1 !== wl) begin
        failures++;
        $display("[TB] FAIL directed%0d_latency got=%0d want=%0d", i, lat1, wl);
      end
    end
  endtask

  // Zero operand with lots of headroom: walks all the way to the floor, counter saturates.
  task automatic test_zero_mantissa;
    res_t d1, d4;
    int lat1, lat4;
    do_op(10'd0, 27'd0, 1'b0, 1'b0, 1'b1, d1, d4, lat1, lat4);
    tests_run++;
    if (d1 !== res_t'{e:10'h382, m:27'd0, g:1'b0, r:1'b0, s:6'd63} || lat1 !== 127) begin
      failures++;
      $display("[TB] FAIL zero_mant got e=%h m=%h s=%0d lat=%0d want e=382 m=0 s=63 lat=127",
               d1.e, d1.m, d1.s, lat1);
    end
    tests_run++;
    if (d4 !== res_t'{e:10'h382, m:27'd0, g:1'b0, r:1'b0, s:6'd63} || lat4 !== 33) begin
      failures++;
      $display("[TB] FAIL zero_mant_step4 got e=%h m=%h s=%0d lat=%0d want e=382 m=0 s=63 lat=33",
               d4.e, d4.m, d4.s, lat4);
    end
  endtask

  task automatic test_random;
    res_t d1, d4, w1, w4;
    int lat1, lat4, wl1, wl4, width;
    logic [31:0] raw;
    logic [26:0] m;
    logic [9:0]  e;
    logic        g, r;
    for (int k = 0; k < 24; k++) begin
      raw   = $urandom;
      width = int'($urandom_range(0, 27));
      m     = raw[26:0] & 27'((64'd1 << width) - 1);
      if ($urandom_range(0, 3) == 0) m[26:24] = 3'($urandom_range(0, 7));
      e = 10'(int'($urandom_range(0, 200)) - 150);
      g = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      model(e, m, g, r, 1, w1, wl1);
      model(e, m, g, r, 4, w4, wl4);
      do_op(e, m, g, r, 1'b1, d1, d4, lat1, lat4);
      tests_run++;
      if (d1 !== w1 || lat1 !== wl1) begin
        failures++;
        $display("[TB] FAIL random%0d in e=%h m=%h g=%b r=%b got e=%h m=%h g=%b r=%b s=%0d lat=%0d want e=%h m=%h g=%b r=%b s=%0d lat=%0d",
                 k, e, m, g, r, d1.e, d1.m, d1.g, d1.r, d1.s, lat1, w1.e, w1.m, w1.g, w1.r, w1.s, wl1);
      end
      tests_run++;
      if (d4 !== w4 || lat4 !== wl4) begin
        failures++;
        $display("[TB] FAIL random%0d_step4 in e=%h m=%h got e=%h m=%h s=%0d lat=%0d want e=%h m=%h s=%0d lat=%0d",
                 k, e, m, d4.e, d4.m, d4.s, lat4, w4.e, w4.m, w4.s, wl4);
      end
    end
  endtask

  task automatic test_backpressure;
    res_t d1, d4, w1;
    int lat1, lat4, wl1;
    model(10'd0, 27'h0200000, 1'b1, 1'b1, 1, w1, wl1);
    do_op(10'd0, 27'h0200000, 1'b1, 1'b1, 1'b0, d1, d4, lat1, lat4);
    tests_run++;
    if (d1 !== w1) begin
      failures++;
      $display("[TB] FAIL bp_result got e=%h m=%h s=%0d want e=%h m=%h s=%0d", d1.e, d1.m, d1.s, w1.e, w1.m, w1.s);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({out_valid, in_ready} !== 2'b10 || {z_e_out, z_m_out, guard_out, round_bit_out, steps} !== w1) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d got v=%b rdy=%b e=%h m=%h s=%0d want v=1 rdy=0 e=%h m=%h s=%0d",
                 c, out_valid, in_ready, z_e_out, z_m_out, steps, w1.e, w1.m, w1.s);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if ({in_ready, out_valid, in_ready4, out_valid4} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL bp_release got=%b want=1010", {in_ready, out_valid, in_ready4, out_valid4});
    end
  endtask

  task automatic test_reset_mid_norm;
    res_t d1, d4, w1, w4;
    int lat1, lat4, wl1, wl4;
    z_e_in = 10'd0; z_m_in = 27'h0200000; guard_in = 1'b1; round_bit_in = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({in_ready, out_valid} !== 2'b10 || {z_e_out, z_m_out, guard_out, round_bit_out, steps} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_norm got v=%b rdy=%b e=%h m=%h s=%0d want v=0 rdy=1 all zero",
               out_valid, in_ready, z_e_out, z_m_out, steps);
    end
    model(10'd40, 27'h0000100, 1'b1, 1'b0, 1, w1, wl1);
    model(10'd40, 27'h0000100, 1'b1, 1'b0, 4, w4, wl4);
    do_op(10'd40, 27'h0000100, 1'b1, 1'b0, 1'b1, d1, d4, lat1, lat4);
    tests_run++;
    if (d1 !== w1 || lat1 !== wl1 || d4 !== w4 || lat4 !== wl4) begin
      failures++;
      $display("[TB] FAIL after_reset got e=%h m=%h s=%0d lat=%0d lat4=%0d want e=%h m=%h s=%0d lat=%0d lat4=%0d",
               d1.e, d1.m, d1.s, lat1, lat4, w1.e, w1.m, w1.s, wl1, wl4);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_mantissa();
    test_random();
    test_backpressure();
    test_reset_mid_norm();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
